// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the up/down key front-end
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  localparam int KEY_ADD  = 0;
  localparam int KEY_SUB  = 1;
  localparam int KEY_HOLD = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 20000;
  localparam int DEF_REPEAT_DELAY    = 5000000;
  localparam int DEF_REPEAT_PERIOD   = 1000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser, debounce counter, debounced level and rising-edge pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any cycle where the synchronised level agrees with the state restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/updown_key_pulser.sv
// rtl/updown_key_pulser.sv - key front-end producing add/sub pulses and a latched hold level
// Auto-repeat logic is built only when UPDOWN_KEY_AUTOREPEAT_EN is defined.
module updown_key_pulser
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_add_raw,
  input  logic key_sub_raw,
  input  logic key_hold_raw,
  output logic add,
  output logic sub,
  output logic hold
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("updown_key_pulser: timing parameters must be at least 1");
  end

  logic [2:0] key_raw, key_lvl, key_rise;

  assign key_raw[KEY_ADD]  = key_add_raw;
  assign key_raw[KEY_SUB]  = key_sub_raw;
  assign key_raw[KEY_HOLD] = key_hold_raw;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (key_raw[i]),
      .level(key_lvl[i]),
      .rise (key_rise[i])
    );
  end

  logic hold_q, lock_q, lock_n, add_q, sub_q, add_n, sub_n;
  logic ev_add, ev_sub;

  // Lockout spans from both keys being down until both are released again.
  assign lock_n = (lock_q | (key_lvl[KEY_ADD] & key_lvl[KEY_SUB]))
                & (key_lvl[KEY_ADD] | key_lvl[KEY_SUB]);
  assign ev_add = key_rise[KEY_ADD] & ~key_lvl[KEY_SUB] & ~lock_q & ~hold_q;
  assign ev_sub = key_rise[KEY_SUB] & ~key_lvl[KEY_ADD] & ~lock_q & ~hold_q;

`ifdef UPDOWN_KEY_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  rep_state_t       state_q, state_n;
  logic             key_q, key_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             rep_pulse, abort, own_lvl, other_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    key_n     = key_q;
    cnt_n     = cnt_q;
    rep_pulse = 1'b0;
    own_lvl   = key_q ? key_lvl[KEY_SUB] : key_lvl[KEY_ADD];
    other_lvl = key_q ? key_lvl[KEY_ADD] : key_lvl[KEY_SUB];
    abort     = hold_q | ~own_lvl | other_lvl;
    case (state_q)
      ST_DELAY: begin
        if (abort) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == DELAY_LAST) begin
          state_n   = ST_REPEAT;
          rep_pulse = 1'b1;
          cnt_n     = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (abort) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          rep_pulse = 1'b1;
          cnt_n     = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // A fresh single-key press always (re)starts the delay for that key.
    if (ev_add || ev_sub) begin
      state_n = ST_DELAY;
      key_n   = ev_sub;
      cnt_n   = '0;
    end
    add_n = ev_add | (rep_pulse & ~key_q);
    sub_n = ev_sub | (rep_pulse & key_q);
  end
`else
  assign add_n = ev_add;
  assign sub_n = ev_sub;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      lock_q <= 1'b0;
      add_q  <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      hold_q <= hold_q ^ key_rise[KEY_HOLD];
      lock_q <= lock_n;
      add_q  <= add_n;
      sub_q  <= sub_n;
    end
  end

  assign add  = add_q;
  assign sub  = sub_q;
  assign hold = hold_q;

endmodule

// File: tb/tb_updown_key_pulser.sv
// tb/tb_updown_key_pulser.sv - randomized and directed checks of updown_key_pulser against a reference model
module tb_updown_key_pulser;

  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst, ka, ks, kh;
  logic add, sub, hold;

  updown_key_pulser #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_add_raw (ka),
    .key_sub_raw (ks),
    .key_hold_raw(kh),
    .add         (add),
    .sub         (sub),
    .hold        (hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model: history of raw samples and reset per edge.
  int cyc = -1;
  bit raw_h [3][MAXC];
  bit rst_h [MAXC];
  bit m_lvl [3];
  bit m_rise[3];
  int m_last[3];
  bit m_hold, m_lock, m_add, m_sub;
  bit act [2];
  int st  [2];

  int add_cnt, sub_cnt, add_first;

  function automatic bit seen(input int key, input int j);
    if (j < 2) return 1'b0;
    if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
    return raw_h[key][j-2];
  endfunction

  task automatic model_edge();
    int k;
    bit pa, ps, ev_a, ev_s, all_diff, lk;
    k = cyc;
    if (rst_h[k]) begin
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 0; m_rise[i] = 0; m_last[i] = k;
      end
      m_hold = 0; m_lock = 0; m_add = 0; m_sub = 0;
      act[0] = 0; act[1] = 0;
      return;
    end
    ev_a = m_rise[0] && !m_lvl[1] && !m_lock && !m_hold;
    ev_s = m_rise[1] && !m_lvl[0] && !m_lock && !m_hold;
    pa = ev_a;
    ps = ev_s;
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
    for (int i = 0; i < 2; i++) begin
      if (act[i] && (!m_lvl[i] || m_lvl[1-i] || m_hold)) act[i] = 0;
      if (act[i]) begin
        int t;
        t = k - st[i];
        if (t == RD || (t > RD && (t - RD) % RP == 0)) begin
          if (i == 0) pa = 1; else ps = 1;
        end
      end
    end
    if (ev_a) begin act[0] = 1; st[0] = k; act[1] = 0; end
    if (ev_s) begin act[1] = 1; st[1] = k; act[0] = 0; end
`endif
    lk = (m_lock || (m_lvl[0] && m_lvl[1])) && (m_lvl[0] || m_lvl[1]);
    m_lock = lk;
    m_hold = m_hold ^ m_rise[2];
    m_add = pa;
    m_sub = ps;
    // Debounced level flips after DB consecutive disagreeing synchronised samples.
    for (int i = 0; i < 3; i++) begin
      m_rise[i] = 0;
      if (k - DB >= m_last[i]) begin
        all_diff = 1;
        for (int j = k - DB + 1; j <= k; j++)
          if (seen(i, j) == m_lvl[i]) all_diff = 0;
        if (all_diff) begin
          m_lvl[i] = !m_lvl[i];
          m_last[i] = k;
          m_rise[i] = m_lvl[i];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic a, input logic s, input logic h);
    rst = r; ka = a; ks = s; kh = h;
    @(posedge clk);
    cyc++;
    rst_h[cyc] = r;
    raw_h[0][cyc] = a;
    raw_h[1][cyc] = s;
    raw_h[2][cyc] = h;
    model_edge();
    @(negedge clk);
    check("add", int'(add), int'(m_add));
    check("sub", int'(sub), int'(m_sub));
    check("hold", int'(hold), int'(m_hold));
    check("excl", int'(add & sub), 0);
    if (add) begin
      add_cnt++;
      if (add_first < 0) add_first = cyc;
    end
    if (sub) sub_cnt++;
  endtask

  task automatic clear_counts();
    add_cnt = 0; sub_cnt = 0; add_first = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int lat;
    int exp_rep;
    bit la, ls, lh;
    int ca, cs, ch;
    rst = 1; ka = 0; ks = 0; kh = 0;
    clear_counts();

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("rst_add", int'(add), 0);
    check("rst_hold", int'(hold), 0);
    while (cyc < 9) step(0, 0, 0, 0);

    // Single add press from edge 10.
    clear_counts();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    idle(20);
    check("s1_cnt", add_cnt, 1);
    check("s1_edge", add_first, 10 + 2 + DB);
    check("s1_sub", sub_cnt, 0);

    // Bouncing sub key.
    clear_counts();
    for (int i = 0; i < 20; i++) step(0, 0, ((i / 2) % 2) == 0, 0);
    idle(10);
    check("s2_sub", sub_cnt, 0);

    // Hold toggling and add suppression while held.
    clear_counts();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    idle(10);
    check("s3_hold_on", int'(hold), 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    idle(10);
    check("s3_add_held", add_cnt, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    idle(10);
    check("s3_hold_off", int'(hold), 0);

    // Long add press.
    clear_counts();
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
    idle(15);
`ifdef UPDOWN_KEY_AUTOREPEAT_EN
    exp_rep = 8;
`else
    exp_rep = 1;
`endif
    check("s4_cnt", add_cnt, exp_rep);

    // Simultaneous press, then a fresh single press.
    clear_counts();
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
    idle(15);
    check("s5_both", add_cnt + sub_cnt, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    idle(15);
    check("s5_fresh", add_cnt, 1);

    // Reset while repeating, key kept down.
    for (int i = 0; i < 25; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("s6_rst_add", int'(add), 0);
    check("s6_rst_sub", int'(sub), 0);
    check("s6_rst_hold", int'(hold), 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 0);
      if (add && lat < 0) lat = i;
    end
    check("s6_lat", lat, DB + 3);
    idle(15);

    // Random key activity with occasional reset.
    la = 0; ls = 0; lh = 0; ca = 1; cs = 1; ch = 1;
    for (int i = 0; i < 1500; i++) begin
      if (--ca == 0) begin la = $urandom_range(0, 1); ca = $urandom_range(1, 40); end
      if (--cs == 0) begin ls = $urandom_range(0, 1); cs = $urandom_range(1, 40); end
      if (--ch == 0) begin lh = ($urandom_range(0, 3) == 0); ch = $urandom_range(1, 30); end
      step($urandom_range(0, 299) == 0, la, ls, lh);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
